// File: rtl/tetris_pkg.sv
// Shared shape constants and scheduler state type for the Tetris piece path.
package tetris_pkg;

  localparam int SHAPE_W = 3;
  localparam int NUM_SHAPES = 7;
  localparam logic [2:0] SHAPE_NONE = 3'd7;
  localparam logic [6:0] BAG_FULL = 7'h7F;

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } sched_state_e;

endpackage

// File: rtl/bag_filter.sv
// Combinational 7-bag filter: decides whether a candidate is new to the bag,
// picks the lowest undealt shape as fallback and computes the updated mask.
module bag_filter
  import tetris_pkg::*;
(
  input  logic [2:0] candidate,
  input  logic [6:0] bag_mask,
  output logic       accept,
  output logic [2:0] fallback_id,
  output logic [6:0] next_mask
);

  logic [7:0] taken;
  logic [2:0] chosen;
  logic [6:0] merged;

  // Id 7 maps onto a permanently set bit so it can never be accepted.
  assign taken = {1'b1, bag_mask};

  // Acceptance and lowest-unset-bit priority encoder
  always_comb begin
    accept = ~taken[candidate];
    fallback_id = 3'd0;
    for (int i = NUM_SHAPES - 1; i >= 0; i--) begin
      if (!bag_mask[i]) begin
        fallback_id = 3'(i);
      end else begin
        fallback_id = fallback_id;
      end
    end
  end

  // Mask after dealing the chosen id, wrapping a completed bag back to empty
  always_comb begin
    if (accept) begin
      chosen = candidate;
    end else begin
      chosen = fallback_id;
    end
    merged = bag_mask | (7'h01 << chosen);
    if (merged == BAG_FULL) begin
      next_mask = 7'h00;
    end else begin
      next_mask = merged;
    end
  end

endmodule

// File: rtl/piece_scheduler.sv
// 7-bag piece scheduler: filters the random shape stream into bags and keeps
// a preview FIFO that the game FSM drains with a valid/pop handshake.
module piece_scheduler
  import tetris_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MAX_TRIES = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [2:0]         shape_id_in,
  input  logic               clear,
  input  logic               pop,
  output logic               piece_valid,
  output logic [2:0]         piece_id,
  output logic [3*DEPTH-1:0] preview_flat,
  output logic [3:0]         count,
  output logic [6:0]         bag_mask,
  output logic               fallback_used
);

  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES - 1);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  sched_state_e state, state_next;
  logic [2:0]    slots [DEPTH];
  logic [2:0]    slots_next [DEPTH];
  logic [3:0]    count_next;
  logic [3:0]    wr_idx;
  logic [TW-1:0] tries, tries_next;
  logic [6:0]    mask_next;

  logic       accept, fallback, pop_take, push_ok, push;
  logic [2:0] fallback_id, push_id;
  logic [6:0] filt_mask;

  bag_filter u_bag_filter (
    .candidate   (shape_id_in),
    .bag_mask    (bag_mask),
    .accept      (accept),
    .fallback_id (fallback_id),
    .next_mask   (filt_mask)
  );

  assign pop_take = pop && (count != 4'd0);
  assign push_ok  = !clear && ((state == S_FILL) || pop_take);
  assign fallback = push_ok && !accept && (tries == TRIES_LAST);
  assign push     = push_ok && (accept || fallback);
  assign push_id  = accept ? shape_id_in : fallback_id;

  // Fill/full tracking
  always_comb begin
    state_next = state;
    case (state)
      S_FILL: begin
        if (!clear && push && !pop_take && (count == DEPTH_C - 4'd1)) begin
          state_next = S_FULL;
        end else begin
          state_next = S_FILL;
        end
      end
      S_FULL: begin
        if (clear || (pop_take && !push)) begin
          state_next = S_FILL;
        end else begin
          state_next = S_FULL;
        end
      end
      default: state_next = S_FILL;
    endcase
  end

  // FIFO shift/insert, bag mask and retry counter update
  always_comb begin
    slots_next = slots;
    count_next = count;
    tries_next = tries;
    mask_next  = bag_mask;
    wr_idx     = count;
    if (clear) begin
      for (int k = 0; k < DEPTH; k++) slots_next[k] = SHAPE_NONE;
      count_next = 4'd0;
      tries_next = '0;
      mask_next  = 7'h00;
    end else begin
      if (pop_take) begin
        for (int k = 0; k < DEPTH - 1; k++) slots_next[k] = slots[k + 1];
        slots_next[DEPTH-1] = SHAPE_NONE;
        wr_idx     = count - 4'd1;
        count_next = count - 4'd1;
      end else begin
        wr_idx = count;
      end
      if (push) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (wr_idx == 4'(k)) begin
            slots_next[k] = push_id;
          end else begin
            slots_next[k] = slots_next[k];
          end
        end
        count_next = count_next + 4'd1;
        mask_next  = filt_mask;
        tries_next = '0;
      end else if (push_ok) begin
        tries_next = tries + TW'(1);
      end else begin
        tries_next = tries;
      end
    end
  end

  // State registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= S_FILL;
      count         <= 4'd0;
      tries         <= '0;
      bag_mask      <= 7'h00;
      fallback_used <= 1'b0;
      for (int k = 0; k < DEPTH; k++) slots[k] <= SHAPE_NONE;
    end else begin
      state         <= state_next;
      count         <= count_next;
      tries         <= tries_next;
      bag_mask      <= mask_next;
      fallback_used <= fallback;
      for (int k = 0; k < DEPTH; k++) slots[k] <= slots_next[k];
    end
  end

  assign piece_valid = (count != 4'd0);
  assign piece_id    = slots[0];

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign preview_flat[3*g+2:3*g] = slots[g];
  end

endmodule

// File: tb/tb_piece_scheduler.sv
// Directed bench for piece_scheduler (DEPTH=4, MAX_TRIES=8).
module tb_piece_scheduler;

  logic        clock;
  logic        resetn;
  logic [2:0]  shape_id_in;
  logic        clear;
  logic        pop;
  logic        piece_valid;
  logic [2:0]  piece_id;
  logic [11:0] preview_flat;
  logic [3:0]  count;
  logic [6:0]  bag_mask;
  logic        fallback_used;

  int checks = 0;
  int errors = 0;

  piece_scheduler #(.DEPTH(4), .MAX_TRIES(8)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .shape_id_in   (shape_id_in),
    .clear         (clear),
    .pop           (pop),
    .piece_valid   (piece_valid),
    .piece_id      (piece_id),
    .preview_flat  (preview_flat),
    .count         (count),
    .bag_mask      (bag_mask),
    .fallback_used (fallback_used)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] shape);
    resetn = 1'b0; clear = 1'b0; pop = 1'b0; shape_id_in = shape;
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(3'd3);
    checks++;
    if (count !== 4'd0 || piece_valid !== 1'b0 || piece_id !== 3'd7 ||
        preview_flat !== 12'hFFF || bag_mask !== 7'h00 || fallback_used !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d valid=%b id=%0d flat=%h mask=%h fb=%b required 0 0 7 fff 00 0",
               count, piece_valid, piece_id, preview_flat, bag_mask, fallback_used);
    end
  endtask

  task automatic test_fallback_order();
    do_reset(3'd3);
    step();
    checks++;
    if (piece_id !== 3'd3 || count !== 4'd1) begin
      errors++; $display("FAIL first_push: id=%0d count=%0d required 3 1", piece_id, count);
    end
    repeat (7) step();
    checks++;
    if (count !== 4'd1 || fallback_used !== 1'b0) begin
      errors++; $display("FAIL reject_hold: count=%0d fb=%b required 1 0", count, fallback_used);
    end
    step();
    checks++;
    if (count !== 4'd2 || preview_flat[5:3] !== 3'd0 || fallback_used !== 1'b1) begin
      errors++; $display("FAIL fallback0: count=%0d slot1=%0d fb=%b required 2 0 1",
                         count, preview_flat[5:3], fallback_used);
    end
    step();
    checks++;
    if (fallback_used !== 1'b0) begin
      errors++; $display("FAIL fallback_pulse: fb=%b required 0", fallback_used);
    end
    repeat (7) step();
    checks++;
    if (count !== 4'd3 || preview_flat[8:6] !== 3'd1 || fallback_used !== 1'b1) begin
      errors++; $display("FAIL fallback1: count=%0d slot2=%0d fb=%b required 3 1 1",
                         count, preview_flat[8:6], fallback_used);
    end
    repeat (8) step();
    checks++;
    if (count !== 4'd4 || preview_flat !== 12'h443 || bag_mask !== 7'h0F) begin
      errors++; $display("FAIL fallback2: count=%0d flat=%h mask=%h required 4 443 0f",
                         count, preview_flat, bag_mask);
    end
  endtask

  task automatic test_fill_and_pop();
    do_reset(3'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      shape_id_in = 3'(i);
    end
    checks++;
    if (count !== 4'd4 || preview_flat !== 12'h688 || bag_mask !== 7'h0F || piece_valid !== 1'b1) begin
      errors++; $display("FAIL fill: count=%0d flat=%h mask=%h valid=%b required 4 688 0f 1",
                         count, preview_flat, bag_mask, piece_valid);
    end
    for (int i = 4; i <= 6; i++) begin
      shape_id_in = 3'(i);
      step();
    end
    checks++;
    if (count !== 4'd4 || preview_flat !== 12'h688 || bag_mask !== 7'h0F) begin
      errors++; $display("FAIL full_hold: count=%0d flat=%h mask=%h required 4 688 0f",
                         count, preview_flat, bag_mask);
    end
    shape_id_in = 3'd4; pop = 1'b1;
    step();
    pop = 1'b0;
    checks++;
    if (piece_id !== 3'd1 || count !== 4'd4 || preview_flat[11:9] !== 3'd4 || bag_mask !== 7'h1F) begin
      errors++; $display("FAIL pop_push_full: id=%0d count=%0d tail=%0d mask=%h required 1 4 4 1f",
                         piece_id, count, preview_flat[11:9], bag_mask);
    end
  endtask

  task automatic test_bag_wrap();
    logic [6:0] exp_mask;
    do_reset(3'd0);
    for (int i = 0; i <= 6; i++) begin
      shape_id_in = 3'(i);
      pop = (i > 0);
      step();
      exp_mask = (i == 6) ? 7'h00 : 7'((8'h01 << (i + 1)) - 8'h01);
      checks++;
      if (bag_mask !== exp_mask || count !== 4'd1 || piece_id !== 3'(i)) begin
        errors++; $display("FAIL bag_deal_%0d: mask=%h count=%0d id=%0d required %h 1 %0d",
                           i, bag_mask, count, piece_id, exp_mask, i);
      end
    end
    shape_id_in = 3'd0;
    step();
    pop = 1'b0;
    checks++;
    if (bag_mask !== 7'h01 || piece_id !== 3'd0 || count !== 4'd1) begin
      errors++; $display("FAIL bag_new: mask=%h id=%0d count=%0d required 01 0 1",
                         bag_mask, piece_id, count);
    end
  endtask

  task automatic test_invalid_id();
    do_reset(3'd7);
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++;
    if (count !== 4'd0 || piece_valid !== 1'b0 || piece_id !== 3'd7) begin
      errors++; $display("FAIL pop_empty: count=%0d valid=%b id=%0d required 0 0 7",
                         count, piece_valid, piece_id);
    end
    repeat (6) step();
    checks++;
    if (count !== 4'd0 || fallback_used !== 1'b0) begin
      errors++; $display("FAIL id7_reject: count=%0d fb=%b required 0 0", count, fallback_used);
    end
    step();
    checks++;
    if (count !== 4'd1 || piece_id !== 3'd0 || fallback_used !== 1'b1) begin
      errors++; $display("FAIL id7_fb0: count=%0d id=%0d fb=%b required 1 0 1",
                         count, piece_id, fallback_used);
    end
    repeat (7) step();
    checks++;
    if (count !== 4'd1 || fallback_used !== 1'b0) begin
      errors++; $display("FAIL id7_wait: count=%0d fb=%b required 1 0", count, fallback_used);
    end
    step();
    checks++;
    if (count !== 4'd2 || preview_flat[5:3] !== 3'd1 || fallback_used !== 1'b1 || bag_mask !== 7'h03) begin
      errors++; $display("FAIL id7_fb1: count=%0d slot1=%0d fb=%b mask=%h required 2 1 1 03",
                         count, preview_flat[5:3], fallback_used, bag_mask);
    end
  endtask

  task automatic test_clear_and_reset();
    do_reset(3'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      shape_id_in = 3'(i);
    end
    checks++;
    if (count !== 4'd3 || bag_mask !== 7'h07) begin
      errors++; $display("FAIL pre_clear: count=%0d mask=%h required 3 07", count, bag_mask);
    end
    clear = 1'b1; pop = 1'b1;
    step();
    clear = 1'b0; pop = 1'b0;
    checks++;
    if (count !== 4'd0 || piece_valid !== 1'b0 || bag_mask !== 7'h00 || preview_flat !== 12'hFFF) begin
      errors++; $display("FAIL clear: count=%0d valid=%b mask=%h flat=%h required 0 0 00 fff",
                         count, piece_valid, bag_mask, preview_flat);
    end
    shape_id_in = 3'd5;
    step();
    shape_id_in = 3'd6;
    step();
    checks++;
    if (count !== 4'd2 || bag_mask !== 7'h60 || piece_id !== 3'd5) begin
      errors++; $display("FAIL refill: count=%0d mask=%h id=%0d required 2 60 5", count, bag_mask, piece_id);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || piece_valid !== 1'b0 || piece_id !== 3'd7 ||
        preview_flat !== 12'hFFF || bag_mask !== 7'h00 || fallback_used !== 1'b0) begin
      errors++; $display("FAIL async_reset: count=%0d valid=%b id=%0d flat=%h mask=%h fb=%b required 0 0 7 fff 00 0",
                         count, piece_valid, piece_id, preview_flat, bag_mask, fallback_used);
    end
    step();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; clear = 1'b0; pop = 1'b0; shape_id_in = 3'd0;
    test_reset();
    test_fallback_order();
    test_fill_and_pop();
    test_bag_wrap();
    test_invalid_id();
    test_clear_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
